// File: rtl/conv_run_ctrl.sv
// conv_run_ctrl: sequences one convolution frame (arm, feed, stall on FIFO fill, drain, done); optional drain timeout via CONV_RUN_CTRL_TIMEOUT_EN
// Latency: state advances one cycle after its trigger; feed_en/feed_restart are registered and track state_o exactly
// Backpressure: feeding pauses once fifo_level >= HI_TH and resumes at fifo_level <= LO_TH; DRAIN waits for the output count
module conv_run_ctrl #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 960,
  parameter int OUT_PIX   = IMG_W * IMG_H,
  parameter int LVL_W     = 10,
  parameter int HI_TH     = 768,
  parameter int LO_TH     = 256,
  parameter int DRAIN_TMO = 4096
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             csr_start,
  input  logic             csr_abort,
  input  logic             csr_irq_clr,
  input  logic             feed_valid,
  input  logic             conv_valid,
  input  logic [LVL_W-1:0] fifo_level,
  output logic             feed_restart,
  output logic             feed_en,
  output logic             busy,
  output logic             done,
  output logic             irq,
  output logic             timeout,
  output logic [2:0]       state_o,
  output logic [31:0]      in_count,
  output logic [31:0]      out_count,
  output logic [31:0]      cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_STALL = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [31:0]      IN_PIX = 32'(IMG_W * IMG_H);
  localparam logic [31:0]      OUT_N  = 32'(OUT_PIX);
  localparam logic [LVL_W-1:0] HI_LVL = LVL_W'(HI_TH);
  localparam logic [LVL_W-1:0] LO_LVL = LVL_W'(LO_TH);

  state_t      state;
  state_t      state_nx;
  logic        abort_hit;
  logic        arm_entry;
  logic        feed_last;
  logic        drain_done;
  logic        drain_tmo;
  logic [31:0] in_nx;
  logic [31:0] out_nx;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  // Abort only means something once a frame has left IDLE
  assign abort_hit  = csr_abort && (state != S_IDLE);
  // ARM is only ever entered from IDLE or DONE, so this marks the start of a new frame
  assign arm_entry  = (state_nx == S_ARM);
  assign in_nx      = sat_inc(in_count, feed_valid);
  assign out_nx     = sat_inc(out_count, conv_valid);
  // The pixel that brings in_count up to the full image ends the feed phase
  assign feed_last  = feed_valid && (in_count == IN_PIX - 32'd1);
  // Completion counts the conv_valid arriving in the same cycle
  assign drain_done = (out_nx == OUT_N);

`ifdef CONV_RUN_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(DRAIN_TMO + 1);
  logic [TW-1:0] drain_cnt;

  // The last allowed DRAIN cycle is the one where the counter reads DRAIN_TMO-1
  assign drain_tmo = (state == S_DRAIN) && (drain_cnt == TW'(DRAIN_TMO - 1));

  // Count cycles spent in DRAIN; restart from zero on every entry
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drain_cnt <= '0;
    end else if (state == S_DRAIN && state_nx == S_DRAIN) begin
      drain_cnt <= drain_cnt + 1'b1;
    end else begin
      drain_cnt <= '0;
    end
  end

  // Sticky flag: DRAIN gave up rather than completing; cleared at frame start
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timeout <= 1'b0;
    end else if (arm_entry) begin
      timeout <= 1'b0;
    end else if (state == S_DRAIN && state_nx == S_DONE && !drain_done) begin
      timeout <= 1'b1;
    end
  end
`else
  assign drain_tmo = 1'b0;
  assign timeout   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_nx = state;
    if (abort_hit) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (csr_start) state_nx = S_ARM;
        S_ARM:          state_nx = S_RUN;
        S_RUN: begin
          if (feed_last)                 state_nx = S_DRAIN;
          else if (fifo_level >= HI_LVL) state_nx = S_STALL;
        end
        S_STALL:        if (fifo_level <= LO_LVL) state_nx = S_RUN;
        S_DRAIN:        if (drain_done || drain_tmo) state_nx = S_DONE;
        default:        state_nx = S_IDLE;
      endcase
    end
  end

  // Status decoded straight from the state register
  always_comb begin
    state_o = state;
    busy    = (state == S_ARM) || (state == S_RUN) || (state == S_STALL) || (state == S_DRAIN);
    done    = (state == S_DONE);
  end

  // Registered controls computed from the next state so they line up with state_o; irq set beats clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      feed_en      <= 1'b0;
      feed_restart <= 1'b0;
      irq          <= 1'b0;
    end else begin
      feed_en      <= (state_nx == S_RUN);
      feed_restart <= (state_nx == S_ARM);
      if (state_nx == S_DONE && state != S_DONE) begin
        irq <= 1'b1;
      end else if (csr_irq_clr && !abort_hit) begin
        irq <= 1'b0;
      end
    end
  end

  // Frame counters: zeroed on ARM entry, then count while busy; an abort freezes them
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_count    <= '0;
      out_count   <= '0;
      cycle_count <= '0;
    end else if (arm_entry) begin
      in_count    <= '0;
      out_count   <= '0;
      cycle_count <= '0;
    end else if (!abort_hit) begin
      case (state)
        S_ARM: begin
          out_count   <= out_nx;
          cycle_count <= sat_inc(cycle_count, 1'b1);
        end
        S_RUN, S_STALL, S_DRAIN: begin
          in_count    <= in_nx;
          out_count   <= out_nx;
          cycle_count <= sat_inc(cycle_count, 1'b1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_run_ctrl.sv
// tb_conv_run_ctrl: randomized frames against a count-based reference of the frame rules
// Drives inputs and samples outputs 1 time unit after each rising clock edge
// Scenarios: nominal, backpressure, abort, drain timeout, restart/irq clear, reset mid-stall
module tb_conv_run_ctrl;
  localparam int NP   = 16;
  localparam int LW   = 10;
  localparam int TMO  = 20;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          csr_start = 1'b0;
  logic          csr_abort = 1'b0;
  logic          csr_irq_clr = 1'b0;
  logic          feed_valid = 1'b0;
  logic          conv_valid = 1'b0;
  logic [LW-1:0] fifo_level = '0;
  logic          feed_restart, feed_en, busy, done, irq, timeout;
  logic [2:0]    state_o;
  logic [31:0]   in_count, out_count, cycle_count;

  int n_chk = 0;
  int n_fail = 0;
  int fed = 0;
  int outd = 0;
  int ecyc = 0;
  int guard;

  conv_run_ctrl #(
    .IMG_W(4), .IMG_H(4), .OUT_PIX(NP), .LVL_W(LW),
    .HI_TH(6), .LO_TH(2), .DRAIN_TMO(TMO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .csr_start(csr_start), .csr_abort(csr_abort), .csr_irq_clr(csr_irq_clr),
    .feed_valid(feed_valid), .conv_valid(conv_valid), .fifo_level(fifo_level),
    .feed_restart(feed_restart), .feed_en(feed_en), .busy(busy), .done(done),
    .irq(irq), .timeout(timeout), .state_o(state_o),
    .in_count(in_count), .out_count(out_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; the reference updates frame counts from what was driven and the phase seen before the edge
  task automatic tick();
    logic [2:0] ps;
    logic ab, st, fv, cv;
    ps = state_o;
    ab = csr_abort && (ps != 3'd0);
    st = csr_start;
    fv = feed_valid;
    cv = conv_valid;
    @(posedge clk);
    #1;
    if (!ab) begin
      if ((ps == 3'd0 || ps == 3'd5) && st) begin
        fed = 0; outd = 0; ecyc = 0;
      end else if (ps == 3'd1) begin
        outd += int'(cv); ecyc++;
      end else if (ps >= 3'd2 && ps <= 3'd4) begin
        fed += int'(fv); outd += int'(cv); ecyc++;
      end
    end
  endtask

  task automatic start_frame();
    csr_start = 1'b1;
    tick();
    csr_start = 1'b0;
    chk("arm_state", state_o, 3'd1);
    chk("arm_restart", feed_restart, 1'b1);
    chk("arm_feed_en", feed_en, 1'b0);
    chk("arm_in_clr", in_count, 32'd0);
    chk("arm_out_clr", out_count, 32'd0);
    chk("arm_cyc_clr", cycle_count, 32'd0);
    tick();
    chk("run_state", state_o, 3'd2);
    chk("run_restart", feed_restart, 1'b0);
    chk("run_feed_en", feed_en, 1'b1);
  endtask

  initial begin
    // Reset
    #2 rstn = 1'b0;
    #1;
    chk("rst_state", state_o, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_irq", irq, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    chk("idle_state", state_o, 3'd0);
    chk("idle_feed_en", feed_en, 1'b0);

    // Nominal frame with random feed/conv gaps; completion held back until DRAIN
    start_frame();
    guard = 0;
    while (fed < NP && guard < 400) begin
      feed_valid = 1'($urandom_range(0, 1));
      conv_valid = (outd < fed && outd < NP - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      fifo_level = LW'($urandom_range(0, 5));
      tick();
      guard++;
      chk("nom_state", state_o, (fed == NP) ? 3'd4 : 3'd2);
      chk("nom_in", in_count, fed);
      chk("nom_out", out_count, outd);
      chk("nom_feed_en", feed_en, (fed < NP) ? 1'b1 : 1'b0);
    end
    feed_valid = 1'b0;
    guard = 0;
    while (outd < NP && guard < 400) begin
      conv_valid = 1'($urandom_range(0, 1));
      tick();
      guard++;
      chk("nom_drain_state", state_o, (outd == NP) ? 3'd5 : 3'd4);
    end
    conv_valid = 1'b0;
    chk("nom_done", done, 1'b1);
    chk("nom_irq", irq, 1'b1);
    chk("nom_busy", busy, 1'b0);
    chk("nom_in_final", in_count, 32'd16);
    chk("nom_out_final", out_count, 32'd16);
    chk("nom_cycles", cycle_count, ecyc);
    chk("nom_timeout", timeout, 1'b0);

    // irq clear in DONE
    csr_irq_clr = 1'b1;
    tick();
    csr_irq_clr = 1'b0;
    chk("clr_irq", irq, 1'b0);
    chk("clr_state", state_o, 3'd5);

    // Restart from DONE, ignored start in RUN, backpressure, DRAIN beats STALL
    start_frame();
    for (int i = 0; i < 5; i++) begin
      feed_valid = 1'b1;
      csr_start = (i == 2);
      tick();
      chk("bp_run_state", state_o, 3'd2);
      chk("bp_run_in", in_count, fed);
    end
    csr_start = 1'b0;
    feed_valid = 1'b0;
    fifo_level = LW'(6);
    tick();
    chk("bp_stall_state", state_o, 3'd3);
    chk("bp_stall_feed_en", feed_en, 1'b0);
    for (int i = 0; i < 5; i++) begin
      fifo_level = LW'($urandom_range(3, 9));
      feed_valid = (i == 2);
      tick();
      chk("bp_hold_state", state_o, 3'd3);
      chk("bp_hold_feed_en", feed_en, 1'b0);
      chk("bp_hold_in", in_count, fed);
    end
    feed_valid = 1'b0;
    fifo_level = LW'(2);
    tick();
    chk("bp_resume_state", state_o, 3'd2);
    chk("bp_resume_feed_en", feed_en, 1'b1);
    while (fed < NP - 1) begin
      fifo_level = LW'($urandom_range(0, 5));
      feed_valid = 1'b1;
      tick();
      chk("bp_feed_state", state_o, 3'd2);
    end
    fifo_level = LW'(6);
    tick();
    feed_valid = 1'b0;
    fifo_level = '0;
    chk("bp_last_drain", state_o, 3'd4);
    chk("bp_last_in", in_count, 32'd16);
    for (int i = 0; i < NP - 1; i++) begin
      conv_valid = 1'b1;
      tick();
      chk("bp_drain_state", state_o, 3'd4);
      chk("bp_drain_out", out_count, outd);
    end
    csr_irq_clr = 1'b1;
    tick();
    conv_valid = 1'b0;
    csr_irq_clr = 1'b0;
    chk("bp_done_state", state_o, 3'd5);
    chk("bp_irq_set_wins", irq, 1'b1);
    chk("bp_out_final", out_count, 32'd16);
    chk("bp_cycles", cycle_count, ecyc);

    // Abort with coincident start at in_count=7
    csr_irq_clr = 1'b1;
    tick();
    csr_irq_clr = 1'b0;
    start_frame();
    for (int i = 0; i < 7; i++) begin
      feed_valid = 1'b1;
      tick();
    end
    chk("ab_in_before", in_count, 32'd7);
    csr_abort = 1'b1;
    csr_start = 1'b1;
    conv_valid = 1'b1;
    tick();
    csr_abort = 1'b0;
    csr_start = 1'b0;
    conv_valid = 1'b0;
    chk("ab_state", state_o, 3'd0);
    chk("ab_in_held", in_count, 32'd7);
    chk("ab_out_held", out_count, outd);
    chk("ab_irq", irq, 1'b0);
    chk("ab_feed_en", feed_en, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ab_idle_state", state_o, 3'd0);
      chk("ab_idle_in", in_count, 32'd7);
    end
    feed_valid = 1'b0;

    // Short output: only 10 conv_valid
    start_frame();
    for (int i = 0; i < NP; i++) begin
      feed_valid = 1'b1;
      conv_valid = (i < 10);
      tick();
      chk("to_feed_state", state_o, (i == NP - 1) ? 3'd4 : 3'd2);
    end
    feed_valid = 1'b0;
    conv_valid = 1'b0;
    chk("to_out", out_count, 32'd10);
`ifdef CONV_RUN_CTRL_TIMEOUT_EN
    for (int k = 1; k <= TMO; k++) begin
      tick();
      chk("to_wait_state", state_o, (k == TMO) ? 3'd5 : 3'd4);
    end
    chk("to_timeout", timeout, 1'b1);
    chk("to_irq", irq, 1'b1);
    chk("to_done", done, 1'b1);
`else
    for (int k = 1; k <= 100; k++) begin
      tick();
      chk("nto_wait_state", state_o, 3'd4);
    end
    chk("nto_timeout", timeout, 1'b0);
    chk("nto_irq", irq, 1'b0);
    chk("nto_busy", busy, 1'b1);
    csr_abort = 1'b1;
    tick();
    csr_abort = 1'b0;
    chk("nto_abort_state", state_o, 3'd0);
`endif

    // Reset while stalled
    start_frame();
    for (int i = 0; i < 3; i++) begin
      feed_valid = 1'b1;
      tick();
    end
    feed_valid = 1'b0;
    fifo_level = LW'(7);
    tick();
    chk("rs_stall_state", state_o, 3'd3);
    #2 rstn = 1'b0;
    #1;
    chk("rs_state", state_o, 3'd0);
    chk("rs_feed_en", feed_en, 1'b0);
    chk("rs_restart", feed_restart, 1'b0);
    chk("rs_busy", busy, 1'b0);
    chk("rs_done", done, 1'b0);
    chk("rs_irq", irq, 1'b0);
    chk("rs_timeout", timeout, 1'b0);
    chk("rs_in", in_count, 32'd0);
    chk("rs_out", out_count, 32'd0);
    chk("rs_cyc", cycle_count, 32'd0);
    fed = 0; outd = 0; ecyc = 0;
    fifo_level = '0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      feed_valid = 1'b1;
      conv_valid = 1'b1;
      tick();
      chk("rs_wait_state", state_o, 3'd0);
      chk("rs_wait_in", in_count, 32'd0);
    end
    feed_valid = 1'b0;
    conv_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_run_ctrl.md
CONV_RUN_CTRL -- requirements
Module: conv_run_ctrl

Interface
REQ-001 The module SHALL have parameter IMG_W, default 640, meaning image width in pixels.
REQ-002 The module SHALL have parameter IMG_H, default 960, meaning image height in pixels.
REQ-003 The module SHALL have parameter OUT_PIX, default IMG_W*IMG_H, meaning the expected convolution output pixel count per frame.
REQ-004 The module SHALL have parameter LVL_W, default 10, meaning the output FIFO fill-level width.
REQ-005 The module SHALL have parameter HI_TH, default 768, meaning the FIFO level at which feeding pauses.
REQ-006 The module SHALL have parameter LO_TH, default 256, meaning the FIFO level at which feeding resumes.
REQ-007 The module SHALL have parameter DRAIN_TMO, default 4096, meaning the maximum number of cycles spent in DRAIN.
REQ-008 The ports SHALL be, in order:
- clk  in  1  the single clock.
- rstn  in  1  asynchronous active-low reset.
- csr_start  in  1  single-cycle start pulse.
- csr_abort  in  1  single-cycle abort pulse.
- csr_irq_clr  in  1  single-cycle irq clear pulse.
- feed_valid  in  1  pixel accepted by the pixel feeder.
- conv_valid  in  1  convolution output pixel written to the FIFO.
- fifo_level  in  LVL_W  output FIFO occupancy.
- feed_restart  out  1  one-cycle pulse that rewinds the feeder's ROM address to 0.
- feed_en  out  1  enables the feeder to advance.
- busy  out  1  high in ARM, RUN, STALL and DRAIN.
- done  out  1  high in DONE.
- irq  out  1  sticky completion interrupt.
- timeout  out  1  sticky drain-timeout flag.
- state_o  out  3  current state encoding.
- in_count  out  32  pixels fed this frame.
- out_count  out  32  pixels output this frame.
- cycle_count  out  32  busy cycles this frame.

Function
REQ-009 The state encoding SHALL be IDLE=0, ARM=1, RUN=2, STALL=3, DRAIN=4, DONE=5.
REQ-010 IDLE or DONE SHALL go to ARM on csr_start, and csr_start SHALL be ignored in every other state.
REQ-011 ARM SHALL last exactly one cycle, assert feed_restart, clear in_count, out_count, cycle_count and timeout, and go to RUN.
REQ-012 In RUN, feed_en SHALL be 1, and each feed_valid SHALL increment in_count.
REQ-013 RUN SHALL go to DRAIN on the cycle where feed_valid increments in_count to IMG_W*IMG_H.
- This condition SHALL take priority over the STALL transition.
REQ-014 RUN SHALL otherwise go to STALL when fifo_level >= HI_TH.
REQ-015 In STALL, feed_en SHALL be 0.
REQ-016 STALL SHALL return to RUN when fifo_level <= LO_TH.
REQ-017 A feed_valid arriving in STALL or DRAIN SHALL still be counted.
REQ-018 Each conv_valid SHALL increment out_count in ARM (after clear), RUN, STALL and DRAIN.
REQ-019 DRAIN SHALL go to DONE when out_count, including the current conv_valid, equals OUT_PIX.
REQ-020 Entry to DONE SHALL set irq, and csr_irq_clr SHALL clear irq.
- If the set and the clear occur in the same cycle, set SHALL win.
REQ-021 csr_abort in any state other than IDLE SHALL go to IDLE on the next edge, with feed_en=0, counters held, and irq unchanged.
- csr_abort SHALL take priority over csr_start and every other transition.
REQ-022 feed_en SHALL be a registered output equal to 1 exactly while state_o=RUN.
REQ-023 feed_restart SHALL be a registered output equal to 1 exactly while state_o=ARM.
REQ-024 cycle_count SHALL increment every cycle while busy=1 and SHALL saturate at 32'hFFFFFFFF.
REQ-025 in_count and out_count SHALL saturate at 32'hFFFFFFFF.
REQ-026 A DRAIN wait counter SHALL count cycles spent in DRAIN.

Reset
REQ-027 While rstn=0, the module SHALL set state to IDLE and all outputs to 0, asynchronously.
REQ-028 A reset asserted mid-frame SHALL discard the frame, and after release the module SHALL wait for csr_start.

Configuration
REQ-029 With CONV_RUN_CTRL_TIMEOUT_EN defined, DRAIN SHALL go to DONE, set timeout=1 and set irq after DRAIN_TMO cycles without completion.
REQ-030 Without CONV_RUN_CTRL_TIMEOUT_EN, DRAIN SHALL wait indefinitely, timeout SHALL be constant 0, and the wait counter SHALL be absent.

Verification
REQ-031 Parameters for all scenarios SHALL be IMG_W=4, IMG_H=4, OUT_PIX=16, HI_TH=6, LO_TH=2, DRAIN_TMO=20.
REQ-032 The bench SHALL cover the following scenarios:
- Nominal: pulse csr_start, then 16 feed_valid and 16 conv_valid with fifo_level=0 -> states 1,2,4,5; feed_restart high one cycle; done=1; irq=1; in_count=16; out_count=16.
- Backpressure: fifo_level=6 after 5 pixels -> state 3 and feed_en=0 next cycle; fifo_level=2 -> state 2 and feed_en=1.
- Abort: csr_abort together with csr_start during RUN at in_count=7 -> IDLE; in_count stays 7; irq=0.
- Timeout (macro on): only 10 conv_valid -> DONE exactly 20 cycles after DRAIN entry; timeout=1; irq=1.
- Timeout (macro off): only 10 conv_valid -> remains in DRAIN after 100 cycles.
- Restart and irq clear: csr_start in DONE -> ARM with counters cleared; csr_irq_clr coincident with DONE entry -> irq=1.
- Reset mid-STALL: rstn low -> all outputs 0 immediately; state_o=0.
